// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: the host-transmit FSM states, mouse command bytes,
// the timer width and the microsecond-to-cycle conversion.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RTS,
    WAIT_FIRST,
    SHIFT,
    ACK,
    WAIT_IDLE,
    FAIL
  } ps2_state_e;

  // Common mouse commands and the device acknowledge byte.
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] CMD_SET_RATE = 8'hF3;
  localparam logic [7:0] ACK_BYTE     = 8'hFA;

  // Enough for the 15 ms start timeout at 108 MHz (1,620,000 cycles).
  localparam int TIMER_W = 21;

  // Frame is {stop, parity, data[7:0]}, shifted out LSB first.
  localparam int FRAME_W = 10;

  function automatic int unsigned us_to_cycles(input int unsigned clk_freq_hz,
                                               input int unsigned us);
    return (clk_freq_hz / 32'd1_000_000) * us;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchroniser for one raw PS/2 line plus a falling-edge detector
// on the synchronised level. Registers reset high to match an idle bus so
// that leaving reset never produces a spurious edge.
module ps2_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic line,
  output logic level,
  output logic fe
);

  logic [1:0] sync_reg;
  logic       prev_reg;

  // Shift the raw line through the synchroniser and remember the last level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg <= 2'b11;
      prev_reg <= 1'b1;
    end else begin
      sync_reg <= {sync_reg[0], line};
      prev_reg <= sync_reg[1];
    end
  end

  assign level = sync_reg[1];
  assign fe    = prev_reg & ~sync_reg[1];

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the clock, issues
// request-to-send, shifts a command byte out on device-generated clock
// edges and checks the device ACK. The open-drain lines are driven through
// registered output-enables (1 = pull low).
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ      = 108000000,
  parameter int unsigned INHIBIT_US       = 120,
  parameter int unsigned RTS_US           = 20,
  parameter int unsigned START_TIMEOUT_US = 15000,
  parameter int unsigned XFER_TIMEOUT_US  = 2000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       err,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  // Terminal timer values: a phase lasting N cycles ends when the timer is N-1.
  localparam logic [TIMER_W-1:0] INHIBIT_LAST =
    TIMER_W'(us_to_cycles(CLK_FREQ_HZ, INHIBIT_US) - 1);
  localparam logic [TIMER_W-1:0] RTS_LAST =
    TIMER_W'(us_to_cycles(CLK_FREQ_HZ, RTS_US) - 1);
  localparam logic [TIMER_W-1:0] START_LAST =
    TIMER_W'(us_to_cycles(CLK_FREQ_HZ, START_TIMEOUT_US) - 1);
  localparam logic [TIMER_W-1:0] XFER_LAST =
    TIMER_W'(us_to_cycles(CLK_FREQ_HZ, XFER_TIMEOUT_US) - 1);

  // bitcnt value once parity and stop have both been put on the line.
  localparam logic [3:0] BITCNT_END = 4'd10;

  ps2_state_e           state_reg, state_next;
  logic [TIMER_W-1:0]   timer_reg;
  logic [3:0]           bitcnt_reg;
  logic [FRAME_W-1:0]   frame_reg;
  logic                 timer_clear;

  logic clk_oe_next, data_oe_next, done_next, err_next, busy_next, tx_ready_next;

  // Synchronised line levels; index 0 is PS2_CLK, index 1 is PS2_DATA.
  logic [1:0] raw_lines, line_level, line_fe;
  logic       clk_s, data_s, clk_fe;
  logic       unused_data_fe;

  assign raw_lines = {ps2_data_i, ps2_clk_i};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_sync
      ps2_line_sync u_sync (
        .clk   (clk),
        .rst   (rst),
        .line  (raw_lines[gi]),
        .level (line_level[gi]),
        .fe    (line_fe[gi])
      );
    end
  endgenerate

  assign clk_s          = line_level[0];
  assign data_s         = line_level[1];
  assign clk_fe         = line_fe[0];
  // Data edges are only needed by the receive path.
  assign unused_data_fe = line_fe[1];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic; device edges take priority over a coincident timeout.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:       if (tx_valid && tx_ready) state_next = INHIBIT;
      INHIBIT:    if (timer_reg == INHIBIT_LAST) state_next = RTS;
      RTS:        if (timer_reg == RTS_LAST) state_next = WAIT_FIRST;
      WAIT_FIRST: begin
        if (clk_fe)                        state_next = SHIFT;
        else if (timer_reg == START_LAST)  state_next = FAIL;
      end
      SHIFT: begin
        if (clk_fe && bitcnt_reg == BITCNT_END) state_next = ACK;
        else if (timer_reg == XFER_LAST)        state_next = FAIL;
      end
      ACK: begin
        if (clk_fe)                       state_next = data_s ? FAIL : WAIT_IDLE;
        else if (timer_reg == XFER_LAST)  state_next = FAIL;
      end
      WAIT_IDLE: begin
        if (clk_s && data_s)              state_next = IDLE;
        else if (timer_reg == XFER_LAST)  state_next = FAIL;
      end
      FAIL:       state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  // Output decode from the upcoming state so the registered outputs line up
  // with the state register.
  always_comb begin
    clk_oe_next  = 1'b0;
    data_oe_next = 1'b0;
    done_next    = 1'b0;
    err_next     = 1'b0;
    case (state_next)
      INHIBIT:    clk_oe_next = 1'b1;
      RTS: begin
        clk_oe_next  = 1'b1;
        data_oe_next = 1'b1;
      end
      WAIT_FIRST: data_oe_next = 1'b1;
      SHIFT: begin
        data_oe_next = ps2_data_oe;
        if (clk_fe) begin
          if (state_reg == WAIT_FIRST)   data_oe_next = ~frame_reg[0];
          else if (bitcnt_reg <= 4'd9)   data_oe_next = ~frame_reg[bitcnt_reg];
        end
      end
      FAIL: begin
        done_next = 1'b1;
        err_next  = 1'b1;
      end
      default: ;
    endcase
    if (state_reg == WAIT_IDLE && state_next == IDLE) done_next = 1'b1;
    busy_next     = (state_next != IDLE);
    // Ready is withheld during the done cycle so it rises one cycle later.
    tx_ready_next = (state_next == IDLE) && !done_next;
  end

  // Output registers: lines released, ready asserted, no pulses in reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      busy        <= 1'b0;
      tx_ready    <= 1'b1;
    end else begin
      ps2_clk_oe  <= clk_oe_next;
      ps2_data_oe <= data_oe_next;
      done        <= done_next;
      err         <= err_next;
      busy        <= busy_next;
      tx_ready    <= tx_ready_next;
    end
  end

  // The transfer timer keeps running from the first device edge through
  // SHIFT, ACK and WAIT_IDLE; every other state change restarts it.
  assign timer_clear = (state_next != state_reg) &&
                       (state_reg != SHIFT) && (state_reg != ACK);

  // Timer, bit counter and frame capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer_reg  <= '0;
      bitcnt_reg <= '0;
      frame_reg  <= '0;
    end else if (state_reg == IDLE) begin
      timer_reg  <= '0;
      bitcnt_reg <= '0;
      if (state_next == INHIBIT) frame_reg <= {1'b1, ~^tx_data, tx_data};
    end else begin
      timer_reg <= timer_clear ? '0 : timer_reg + 1'b1;
      if (state_reg == WAIT_FIRST && clk_fe)
        bitcnt_reg <= 4'd1;
      else if (state_reg == SHIFT && clk_fe && bitcnt_reg != BITCNT_END)
        bitcnt_reg <= bitcnt_reg + 4'd1;
    end
  end

endmodule
